// File: rtl/el_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : el_pkg
// Brief    : Shared types and rail codes for the elastic dual-rail blocks.
// Revision : 1.0
// ---------------------------------------------------------------------------
package el_pkg;

    typedef enum logic [0:0] {
        WAIT_DATA = 1'b0,
        WAIT_NULL = 1'b1
    } el_state_t;

    // Rail pair encoding {rail1, rail0} for one data bit
    localparam logic [1:0] DR_NULL    = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/el_dr_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : el_dr_sync
// Brief    : Multi-bit flop-chain synchroniser, asynchronous reset.
// Revision : 1.0
// ---------------------------------------------------------------------------
module el_dr_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_stage;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_stage[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/el_dr_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : el_dr_capture
// Brief    : Dual-rail to synchronous capture bridge with four-phase ack,
//            FWFT FIFO, word counter and sticky error/overflow flags.
// Revision : 1.0
// ---------------------------------------------------------------------------
module el_dr_capture
    import el_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [2*WIDTH-1:0] dr_in,
    output logic               ack_o,
    input  logic               auto_ack_en,
    input  logic               ack_ext_i,
    output logic [WIDTH-1:0]   data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [15:0]        count_o,
    output logic               err_o,
    output logic               ovf_o,
    input  logic               clear_i
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = DEPTH[c_PTR_W:0];

    logic [2*WIDTH-1:0] w_s;
    logic               w_complete;
    logic               w_spacer;
    logic               w_illegal;
    logic [WIDTH-1:0]   w_word;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    el_state_t          w_state_nxt;

    el_state_t          r_state;
    logic               r_ack;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_fill;
    logic [15:0]        r_count;
    logic               r_err;
    logic               r_ovf;

    el_dr_sync #(
        .WIDTH       (2*WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .i_d (dr_in),
        .o_q (w_s)
    );

    // An illegal pair is neither valid nor null, so it blocks both completion and spacer
    always_comb begin
        w_complete = 1'b1;
        w_spacer   = 1'b1;
        w_illegal  = 1'b0;
        w_word     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_s[2*i +: 2] != DR_ZERO && w_s[2*i +: 2] != DR_ONE) begin
                w_complete = 1'b0;
            end
            if (w_s[2*i +: 2] != DR_NULL) begin
                w_spacer = 1'b0;
            end
            if (w_s[2*i +: 2] == DR_ILLEGAL) begin
                w_illegal = 1'b1;
            end
            w_word[i] = (w_s[2*i +: 2] == DR_ONE);
        end
    end

    assign w_full  = (r_fill == c_FULL);
    assign w_pop   = valid_o && ready_i;
    assign w_push  = (r_state == WAIT_DATA) && w_complete && !w_full;
    assign w_drop  = (r_state == WAIT_DATA) && w_complete && w_full && !auto_ack_en;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            WAIT_DATA: if (w_push || w_drop) w_state_nxt = WAIT_NULL;
            WAIT_NULL: if (w_spacer)         w_state_nxt = WAIT_DATA;
            default:                         w_state_nxt = WAIT_DATA;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= WAIT_DATA;
            r_ack    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            // Auto ack mirrors the phase being entered so it rises with the push
            r_ack   <= auto_ack_en ? (w_state_nxt == WAIT_NULL) : ack_ext_i;
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_count         <= r_count + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            r_err <= (r_err && !clear_i) || w_illegal;
            r_ovf <= (r_ovf && !clear_i) || w_drop;
        end
    end

    assign ack_o   = r_ack;
    assign data_o  = r_mem[r_rd_ptr];
    assign valid_o = (r_fill != '0);
    assign count_o = r_count;
    assign err_o   = r_err;
    assign ovf_o   = r_ovf;

endmodule
`default_nettype wire
